// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for MIPS div/divu: quotient to LO, remainder to HI.
// One quotient bit per cycle on operand magnitudes, sign-corrected when leaving CALC.
//
// state  | meaning
// IDLE   | waiting for div_start, accepts a new request
// CALC   | 32 shift/subtract iterations, cnt_q counts 0..31
// FINISH | result valid on div_lo/div_hi, div_ready pulses
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_cancel,
    output logic        div_busy,
    output logic        div_ready,
    output logic [31:0] div_lo,
    output logic [31:0] div_hi
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] work_q;
    logic [31:0] divisor_q;
    logic [31:0] src1_raw_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dz_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] shifted;
    logic [32:0] trial;
    logic [63:0] work_d;
    logic [31:0] lo_d;
    logic [31:0] hi_d;

    assign a_mag = (div_signed && div_src1[31]) ? -div_src1 : div_src1;
    assign b_mag = (div_signed && div_src2[31]) ? -div_src2 : div_src2;

    // Upper half never overflows on the shift: before the last step it holds a remainder below 2^31.
    assign shifted = {work_q[62:0], 1'b0};
    assign trial   = {1'b0, shifted[63:32]} - {1'b0, divisor_q};
    assign work_d  = trial[32] ? shifted : {trial[31:0], shifted[31:1], 1'b1};

    // Divide by zero reports all-ones and the untouched dividend, independent of signedness.
    assign lo_d = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? -work_d[31:0]  : work_d[31:0]);
    assign hi_d = dz_q ? src1_raw_q    : (r_neg_q ? -work_d[63:32] : work_d[63:32]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            work_q     <= 64'd0;
            divisor_q  <= 32'd0;
            src1_raw_q <= 32'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            lo_q       <= 32'd0;
            hi_q       <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_start && !div_cancel) begin
                        state_q    <= CALC;
                        cnt_q      <= 5'd0;
                        work_q     <= {32'd0, a_mag};
                        divisor_q  <= b_mag;
                        src1_raw_q <= div_src1;
                        q_neg_q    <= div_signed & (div_src1[31] ^ div_src2[31]);
                        r_neg_q    <= div_signed & div_src1[31];
                        dz_q       <= (div_src2 == 32'd0);
                    end
                end
                CALC: begin
                    if (div_cancel) begin
                        state_q <= IDLE;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= FINISH;
                            lo_q    <= lo_d;
                            hi_q    <= hi_d;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_busy  = ~rst & ((state_q == CALC) |
                               ((state_q == IDLE) & div_start & ~div_cancel));
    assign div_ready = (state_q == FINISH) & ~div_cancel;
    assign div_lo    = lo_q;
    assign div_hi    = hi_q;

endmodule
